// File: rtl/sodor5_stim_pkg.sv
// Shared constants, FSM state type and instruction encoders for the
// itype_stim_gen stimulus source.
// Optional feature macro: ITYPE_LOAD_MIX_EN adds the LB/LBU encoder used
// when the load mix is enabled.
package sodor5_stim_pkg;

    localparam logic [6:0]  OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD      = 7'b0000011;
    localparam logic [31:0] NOP_INSTR     = 32'h00000013;
    localparam logic [2:0]  F3_SLLI       = 3'd1;
    localparam logic [2:0]  F3_SRXI       = 3'd5;
    localparam logic [11:0] SHAMT_MASK    = 12'h01F;
    localparam logic [11:0] SRXI_MASK     = 12'h41F;
    localparam logic [11:0] LOAD_IMM_MASK = 12'h03F;
    localparam logic [2:0]  LOAD_F3_MASK  = 3'b100;
    localparam logic [31:0] LFSR_POLY     = 32'h80200003;

    typedef enum logic [1:0] {
        ST_WARMUP = 2'd0,
        ST_RUN    = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    // Takes only L[31:7]; the low opcode bits of L never reach the word.
    function automatic logic [31:0] encode_opimm(input logic [31:7] f);
        logic [11:0] imm;
        imm = f[31:20];
        // Shift immediates must keep funct7 legal: SLLI needs it zero,
        // SRLI/SRAI keep only bit 10 as the arithmetic selector.
        if (f[14:12] == F3_SLLI) begin
            imm = imm & SHAMT_MASK;
        end else if (f[14:12] == F3_SRXI) begin
            imm = imm & SRXI_MASK;
        end
        return {imm, f[19:15], f[14:12], f[11:7], OPC_OP_IMM};
    endfunction

`ifdef ITYPE_LOAD_MIX_EN
    // LB/LBU from x0 into the first 64 bytes of dmem; no shift masking.
    function automatic logic [31:0] encode_load(input logic [31:7] f);
        return {f[31:20] & LOAD_IMM_MASK, 5'd0, f[14:12] & LOAD_F3_MASK,
                f[11:7], OPC_LOAD};
    endfunction

    function automatic logic [31:0] encode_mix(input logic [31:7] f,
                                               input logic       sel);
        return sel ? encode_load(f) : encode_opimm(f);
    endfunction
`endif

endpackage

// File: rtl/stim_lfsr32.sv
// 32-bit Galois LFSR for the stimulus generator. Loads SEED on reset and
// advances once per cycle with step high. Exposes the value it will hold
// after the next step, so the caller can encode the next instruction on
// the same edge that advances the register.
// Ports:
//   clk         clock
//   reset_n     asynchronous active-low reset (loads SEED)
//   step        advance one position
//   next_fields bits [31:7] of the post-step value
//   next_sel    bit 0 of the post-step value (only with ITYPE_LOAD_MIX_EN)
// Optional feature macro: ITYPE_LOAD_MIX_EN.
module stim_lfsr32
    import sodor5_stim_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h00000001
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        step,
    output logic [31:7] next_fields
`ifdef ITYPE_LOAD_MIX_EN
    ,
    output logic        next_sel
`endif
);

    logic [31:0] value_q;
    logic [31:0] value_nxt;

    assign value_nxt = value_q[0] ? ((value_q >> 1) ^ LFSR_POLY) : (value_q >> 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            value_q <= SEED;
        end else if (step) begin
            value_q <= value_nxt;
        end
    end

    assign next_fields = value_nxt[31:7];
`ifdef ITYPE_LOAD_MIX_EN
    assign next_sel = value_nxt[0];
`endif

endmodule

// File: rtl/itype_stim_gen.sv
// Deterministic RV32I OP-IMM instruction source on a valid/ready port.
// Sends WARMUP NOPs, then NUM_INSTR LFSR-derived instructions (unbounded
// when NUM_INSTR is 0), then NOPs forever. instr always holds the encoding
// of the current LFSR value while in RUN.
// Ports:
//   clk          clock
//   reset_n      asynchronous active-low reset
//   instr_ready  downstream accepts instr this cycle
//   instr_valid  instr is valid (high from the first edge after reset)
//   instr        instruction word, stable while not accepted
//   done         NUM_INSTR random instructions have been accepted
//   issued_count random instructions accepted, saturating
// Optional feature macro: ITYPE_LOAD_MIX_EN mixes LB/LBU loads into the
// random stream when bit 0 of the LFSR value is set.
//
// state     | meaning
// ----------+---------------------------------------------------------
// ST_WARMUP | emitting NOPs, down-counter tracks remaining warm-up NOPs
// ST_RUN    | emitting encode(L), one LFSR step per accepted instruction
// ST_DONE   | emitting NOPs forever, LFSR and count frozen
module itype_stim_gen
    import sodor5_stim_pkg::*;
#(
    parameter logic [31:0] SEED      = 32'h000002DF,
    parameter int unsigned WARMUP    = 4,
    parameter int unsigned NUM_INSTR = 64,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             instr_ready,
    output logic             instr_valid,
    output logic [31:0]      instr,
    output logic             done,
    output logic [CNT_W-1:0] issued_count
);

    // A zero seed would lock the LFSR at zero.
    localparam logic [31:0]         SEED_EFF  = (SEED == 32'd0) ? 32'd1 : SEED;
    localparam int unsigned         WCNT_W    = (WARMUP > 1) ? $clog2(WARMUP + 1) : 1;
    localparam logic [WCNT_W-1:0]   WARMUP_LD = WCNT_W'(WARMUP);
    localparam logic [CNT_W-1:0]    NUM_LIMIT = CNT_W'(NUM_INSTR);
`ifdef ITYPE_LOAD_MIX_EN
    localparam logic [31:0]         ENC_SEED  = encode_mix(SEED_EFF[31:7], SEED_EFF[0]);
`else
    localparam logic [31:0]         ENC_SEED  = encode_opimm(SEED_EFF[31:7]);
`endif

    state_t              state_q;
    state_t              state_d;
    logic [WCNT_W-1:0]   warm_cnt_q;
    logic [WCNT_W-1:0]   warm_cnt_d;
    logic [31:0]         instr_d;
    logic                done_d;
    logic [CNT_W-1:0]    count_d;
    logic [CNT_W-1:0]    count_inc;
    logic                fire;
    logic                last_warm;
    logic                hit_limit;
    logic                lfsr_step;
    logic [31:7]         next_fields;
    logic [31:0]         enc_next;

    assign fire      = instr_valid & instr_ready;
    assign last_warm = (warm_cnt_q == WCNT_W'(1));
    assign count_inc = (&issued_count) ? issued_count : issued_count + 1'b1;
    assign hit_limit = (NUM_INSTR != 0) && (count_inc == NUM_LIMIT);

`ifdef ITYPE_LOAD_MIX_EN
    logic next_sel;

    stim_lfsr32 #(.SEED(SEED_EFF)) u_lfsr (
        .clk         (clk),
        .reset_n     (reset_n),
        .step        (lfsr_step),
        .next_fields (next_fields),
        .next_sel    (next_sel)
    );

    assign enc_next = encode_mix(next_fields, next_sel);
`else
    stim_lfsr32 #(.SEED(SEED_EFF)) u_lfsr (
        .clk         (clk),
        .reset_n     (reset_n),
        .step        (lfsr_step),
        .next_fields (next_fields)
    );

    assign enc_next = encode_opimm(next_fields);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_WARMUP;
        end else begin
            state_q <= state_d;
        end
    end

    // The first edge after reset (valid still low) is where a zero-length
    // warm-up skips straight to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_WARMUP: begin
                if (!instr_valid) begin
                    if (WARMUP == 0) state_d = ST_RUN;
                end else if (fire && last_warm) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (fire && hit_limit) state_d = ST_DONE;
            end
            default: state_d = state_q;
        endcase
    end

    always_comb begin
        instr_d    = instr;
        done_d     = done;
        count_d    = issued_count;
        warm_cnt_d = warm_cnt_q;
        lfsr_step  = 1'b0;
        case (state_q)
            ST_WARMUP: begin
                if (!instr_valid) begin
                    if (WARMUP == 0) instr_d = ENC_SEED;
                end else if (fire) begin
                    warm_cnt_d = warm_cnt_q - 1'b1;
                    if (last_warm) instr_d = ENC_SEED;
                end
            end
            ST_RUN: begin
                if (fire) begin
                    lfsr_step = 1'b1;
                    count_d   = count_inc;
                    if (hit_limit) begin
                        instr_d = NOP_INSTR;
                        done_d  = 1'b1;
                    end else begin
                        instr_d = enc_next;
                    end
                end
            end
            default: begin
                instr_d = NOP_INSTR;
                done_d  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            done         <= 1'b0;
            issued_count <= '0;
            warm_cnt_q   <= WARMUP_LD;
        end else begin
            instr_valid  <= 1'b1;
            instr        <= instr_d;
            done         <= done_d;
            issued_count <= count_d;
            warm_cnt_q   <= warm_cnt_d;
        end
    end

endmodule

// File: tb/tb_itype_stim_gen.sv
// Directed bench for itype_stim_gen: reset values, warm-up, shift-immediate
// legalisation, back-pressure, DONE, count saturation and mid-stream reset.
module tb_itype_stim_gen;

    localparam logic [31:0] NOP = 32'h00000013;
`ifdef ITYPE_LOAD_MIX_EN
    localparam logic [31:0] EXP_FIRST = 32'h00000283;
    localparam logic [31:0] EXP_SLLI  = 32'h03F00083;
    localparam logic [31:0] EXP_SRAI  = 32'h03F04083;
`else
    localparam logic [31:0] EXP_FIRST = 32'h00000293;
    localparam logic [31:0] EXP_SLLI  = 32'h01F09093;
    localparam logic [31:0] EXP_SRAI  = 32'h41F0D093;
`endif
    localparam logic [31:0] EXP_SECOND = 32'h80200113;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic ready_def;

    logic        d_valid, d_done;
    logic [31:0] d_instr;
    logic [15:0] d_cnt;
    logic        sl_valid, sl_done;
    logic [31:0] sl_instr;
    logic [15:0] sl_cnt;
    logic        sr_valid, sr_done;
    logic [31:0] sr_instr;
    logic [15:0] sr_cnt;
    logic        n3_valid, n3_done;
    logic [31:0] n3_instr;
    logic [15:0] n3_cnt;
    logic        st_valid, st_done;
    logic [31:0] st_instr;
    logic [1:0]  st_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_stream [0:15];

    itype_stim_gen u_def (
        .clk(clk), .reset_n(reset_n), .instr_ready(ready_def),
        .instr_valid(d_valid), .instr(d_instr), .done(d_done), .issued_count(d_cnt)
    );

    itype_stim_gen #(.SEED(32'hFFF09093), .WARMUP(0)) u_sll (
        .clk(clk), .reset_n(reset_n), .instr_ready(1'b1),
        .instr_valid(sl_valid), .instr(sl_instr), .done(sl_done), .issued_count(sl_cnt)
    );

    itype_stim_gen #(.SEED(32'hFFF0D093), .WARMUP(0)) u_sra (
        .clk(clk), .reset_n(reset_n), .instr_ready(1'b1),
        .instr_valid(sr_valid), .instr(sr_instr), .done(sr_done), .issued_count(sr_cnt)
    );

    itype_stim_gen #(.NUM_INSTR(3), .WARMUP(0)) u_n3 (
        .clk(clk), .reset_n(reset_n), .instr_ready(1'b1),
        .instr_valid(n3_valid), .instr(n3_instr), .done(n3_done), .issued_count(n3_cnt)
    );

    itype_stim_gen #(.NUM_INSTR(0), .WARMUP(0), .CNT_W(2)) u_sat (
        .clk(clk), .reset_n(reset_n), .instr_ready(1'b1),
        .instr_valid(st_valid), .instr(st_instr), .done(st_done), .issued_count(st_cnt)
    );

    function automatic logic [31:0] m_step(input logic [31:0] l);
        return l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
    endfunction

    function automatic logic [31:0] m_enc(input logic [31:0] l);
        logic [11:0] imm;
        imm = l[31:20];
`ifdef ITYPE_LOAD_MIX_EN
        if (l[0]) return {l[31:20] & 12'h03F, 5'd0, l[14:12] & 3'b100, l[11:7], 7'b0000011};
`endif
        if (l[14:12] == 3'd1) imm = imm & 12'h01F;
        else if (l[14:12] == 3'd5) imm = imm & 12'h41F;
        return {imm, l[19:15], l[14:12], l[11:7], 7'b0010011};
    endfunction

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (d_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_valid got=%b want=0", d_valid);
        end
        checks++;
        if (d_instr !== NOP) begin
            failures++;
            $display("FAIL reset_instr got=%h want=%h", d_instr, NOP);
        end
        checks++;
        if (d_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_done got=%b want=0", d_done);
        end
        checks++;
        if (d_cnt !== 16'd0) begin
            failures++;
            $display("FAIL reset_count got=%0d want=0", d_cnt);
        end
    endtask

    task automatic test_warmup();
        ready_def = 1'b1;
        apply_reset();
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            checks++;
            if (d_instr !== NOP || d_valid !== 1'b1) begin
                failures++;
                $display("FAIL warmup_nop[%0d] got instr=%h valid=%b want instr=%h valid=1",
                         i, d_instr, d_valid, NOP);
            end
        end
        @(negedge clk);
        checks++;
        if (d_instr !== EXP_FIRST || d_cnt !== 16'd0) begin
            failures++;
            $display("FAIL first_random got instr=%h count=%0d want instr=%h count=0",
                     d_instr, d_cnt, EXP_FIRST);
        end
        @(negedge clk);
        checks++;
        if (d_instr !== EXP_SECOND || d_cnt !== 16'd1) begin
            failures++;
            $display("FAIL second_random got instr=%h count=%0d want instr=%h count=1",
                     d_instr, d_cnt, EXP_SECOND);
        end
    endtask

    task automatic test_shift_mask();
        apply_reset();
        @(negedge clk);
        checks++;
        if (sl_instr !== EXP_SLLI || sl_valid !== 1'b1) begin
            failures++;
            $display("FAIL slli_mask got instr=%h valid=%b want instr=%h valid=1",
                     sl_instr, sl_valid, EXP_SLLI);
        end
        checks++;
        if (sr_instr !== EXP_SRAI || sr_valid !== 1'b1) begin
            failures++;
            $display("FAIL srai_mask got instr=%h valid=%b want instr=%h valid=1",
                     sr_instr, sr_valid, EXP_SRAI);
        end
    endtask

    task automatic test_back_pressure();
        int k;
        ready_def = 1'b1;
        apply_reset();
        repeat (5) @(negedge clk);
        k = 0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            checks++;
            if (d_instr !== exp_stream[k] || d_cnt !== 16'(k)) begin
                failures++;
                $display("FAIL backpressure[%0d] got instr=%h count=%0d want instr=%h count=%0d",
                         cyc, d_instr, d_cnt, exp_stream[k], k);
            end
            ready_def = (cyc >= 3 && cyc <= 7) ? 1'b0 : 1'b1;
            if (ready_def) k++;
            @(negedge clk);
        end
        ready_def = 1'b1;
    endtask

    task automatic test_done();
        apply_reset();
        for (int e = 1; e <= 3; e++) begin
            @(negedge clk);
            checks++;
            if (n3_instr !== exp_stream[e-1] || n3_done !== 1'b0 || n3_cnt !== 16'(e-1)) begin
                failures++;
                $display("FAIL n3_run[%0d] got instr=%h done=%b count=%0d want instr=%h done=0 count=%0d",
                         e, n3_instr, n3_done, n3_cnt, exp_stream[e-1], e-1);
            end
        end
        for (int e = 4; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (n3_instr !== NOP || n3_done !== 1'b1 || n3_valid !== 1'b1 || n3_cnt !== 16'd3) begin
                failures++;
                $display("FAIL n3_done[%0d] got instr=%h done=%b valid=%b count=%0d want instr=%h done=1 valid=1 count=3",
                         e, n3_instr, n3_done, n3_valid, n3_cnt, NOP);
            end
        end
    endtask

    task automatic test_saturate();
        apply_reset();
        for (int e = 1; e <= 7; e++) begin
            @(negedge clk);
            checks++;
            if (st_cnt !== ((e - 1 > 3) ? 2'd3 : 2'(e - 1)) || st_done !== 1'b0) begin
                failures++;
                $display("FAIL saturate[%0d] got count=%0d done=%b want count=%0d done=0",
                         e, st_cnt, st_done, (e - 1 > 3) ? 3 : e - 1);
            end
        end
    endtask

    task automatic test_reset_mid();
        ready_def = 1'b1;
        apply_reset();
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (d_instr !== exp_stream[i]) begin
                failures++;
                $display("FAIL run1[%0d] got=%h want=%h", i, d_instr, exp_stream[i]);
            end
            @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (d_valid !== 1'b0 || d_instr !== NOP || d_cnt !== 16'd0 || d_done !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got valid=%b instr=%h count=%0d done=%b want valid=0 instr=%h count=0 done=0",
                     d_valid, d_instr, d_cnt, d_done, NOP);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (d_instr !== exp_stream[i]) begin
                failures++;
                $display("FAIL replay[%0d] got=%h want=%h", i, d_instr, exp_stream[i]);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        logic [31:0] l;
        reset_n   = 1'b0;
        ready_def = 1'b1;
        l = 32'h000002DF;
        for (int i = 0; i < 16; i++) begin
            exp_stream[i] = m_enc(l);
            l = m_step(l);
        end

        test_reset();
        test_warmup();
        test_shift_mask();
        test_back_pressure();
        test_done();
        test_saturate();
        test_reset_mid();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/itype_stim_gen.md
Name: itype_stim_gen

Overview:
- Synthesizable upstream stimulus source for the sodor5 lock-step verification harness (core vs. ISA model).
- Produces a deterministic pseudo-random stream of legal RV32I OP-IMM instructions from a seeded LFSR, presented on a valid/ready port into the shared instruction input of the core and the model.
- Issues NOP warm-up, then a bounded random run, then NOPs forever, with shift immediates legalised.

Parameters:
- SEED, 32'h000002DF, LFSR seed; a value of 0 is replaced by 32'h00000001.
- WARMUP, 4, number of NOPs accepted before random issue starts (0 allowed).
- NUM_INSTR, 64, random instructions issued before DONE; 0 = unlimited.
- CNT_W, 16, width of issued_count.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- instr_ready  in  1  downstream accepts instr this cycle.
- instr_valid  out  1  instr is valid.
- instr  out  32  instruction word.
- done  out  1  NUM_INSTR random instructions have been accepted.
- issued_count  out  CNT_W  random (non-warm-up) instructions accepted; saturates at all-ones.

Behaviour:
- Reset (async assert, sync release):
  - instr_valid=0, instr=32'h00000013, done=0, issued_count=0.
  - state=WARMUP, LFSR=SEED.
- fire = instr_valid & instr_ready. On !fire, instr is held stable. On fire, instr updates the same edge; zero bubbles.
- First edge after reset release: instr_valid=1. It stays 1 until the next reset.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1 (mask 32'h80200003).
  - Advances exactly once per fire in RUN only, so the sequence is independent of back-pressure.
- Encoding of the current LFSR value L:
  - imm=L[31:20], rs1=L[19:15], funct3=L[14:12], rd=L[11:7], opcode=7'b0010011.
  - funct3==1: imm &= 12'h01F.
  - funct3==5: imm &= 12'h41F (keeps SRLI/SRAI selector bit 10).
- State machine WARMUP -> RUN -> DONE:
  - WARMUP:
    - Emits NOP.
    - A down-counter is loaded with WARMUP and decrements per fire.
    - When the last warm-up NOP fires, go to RUN and load instr=encode(SEED).
    - WARMUP==0: the first valid instr is already encode(SEED) and state is RUN.
  - RUN:
    - On fire, increment issued_count and step the LFSR.
    - If the new count == NUM_INSTR (NUM_INSTR!=0): go to DONE, instr=NOP, done=1 on that same edge.
    - Otherwise load instr=encode(next L).
  - DONE:
    - Emits NOP with instr_valid=1 forever.
    - done stays 1; LFSR and count are frozen.
- issued_count saturates and never wraps. With NUM_INSTR=0, RUN never exits.
- Reset mid-stream: everything returns to reset values immediately. The post-reset sequence is identical to the first run.

Optional Feature:
- Macro: ITYPE_LOAD_MIX_EN.
- Defined:
  - When L[0]==1 in RUN, emit a load instead of OP-IMM: opcode=7'b0000011, funct3=L[14:12]&3'b100 (LB/LBU), rs1=x0, imm=L[31:20]&12'h03F (dmem words 0..15).
  - Shift masking is not applied to loads.
  - Loads count in issued_count.
- Undefined: pure OP-IMM stream; L[0] has no effect.

Decomposition:
- Package sodor5_stim_pkg:
  - OPC_OP_IMM, OPC_LOAD, NOP_INSTR=32'h00000013.
  - F3_SLLI=1, F3_SRXI=5, SHAMT_MASK=12'h01F, SRXI_MASK=12'h41F, LFSR_POLY.
  - State enum {WARMUP, RUN, DONE}.
- One sub-module: stim_lfsr32 (seed load, step enable, async active-low reset).
- Encoding is a combinational function in the package.

Test Plan:
- Defaults, instr_ready=1:
  - Cycles 1-4 after release: instr=32'h00000013.
  - Next instr=32'h00000293 (addi x5,x0,0).
  - issued_count=1 one cycle later.
- SEED=32'hFFF09093, WARMUP=0 -> first instr=32'h01F09093 (slli x1,x1,31; imm masked).
- SEED=32'hFFF0D093, WARMUP=0 -> first instr=32'h41F0D093 (srai x1,x1,31).
- Hold instr_ready=0 for 5 cycles mid-RUN:
  - instr and issued_count are stable.
  - After release, the sequence is identical to the ready=1 run.
- NUM_INSTR=3, WARMUP=0, ready=1:
  - done rises on the 3rd edge after valid.
  - instr=NOP and valid=1 thereafter; issued_count=3.
- Pull reset_n low for 1 cycle mid-RUN:
  - Outputs return to reset values asynchronously.
  - The replayed stream matches the first 10 instructions bit-exactly.
